// File: rtl/tile_layer_pkg.sv
// tile_layer_pkg: shared constants and width helpers for the tile layer.
package tile_layer_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MAP   = 2'd1;
   localparam logic [1:0] ST_REQ   = 2'd2;
   localparam logic [1:0] ST_READY = 2'd3;

   localparam logic TRANSPARENT = 1'b0;

   function automatic int rom_aw(input int hi_bits);
      return 8 + hi_bits + 3;
   endfunction

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/tile_layer_if.sv
// tile_layer_if: CPU map-RAM bus and graphics ROM port of the tile layer.
interface tile_layer_if #(
   parameter int MAP_COLS_LOG2 = 6,
   parameter int MAP_ROWS_LOG2 = 5,
   parameter int BPP           = 2,
   parameter int CODE_HI_BITS  = 2
);
   localparam int AW  = MAP_COLS_LOG2 + MAP_ROWS_LOG2;
   localparam int RAW = tile_layer_pkg::rom_aw(CODE_HI_BITS);

   logic [AW-1:0]      cpu_addr;
   logic [7:0]         cpu_din;
   logic               cpu_wr_n;
   logic               code_cs_n;
   logic               attr_cs_n;
   logic [7:0]         code_dout;
   logic [7:0]         attr_dout;
   logic               cpu_wait_n;
   logic               rom_req;
   logic [RAW-1:0]     rom_addr;
   logic [BPP*8-1:0]   rom_data;
   logic               rom_valid;

   modport master (
      output cpu_addr, cpu_din, cpu_wr_n, code_cs_n, attr_cs_n,
      output rom_data, rom_valid,
      input  code_dout, attr_dout, cpu_wait_n, rom_req, rom_addr
   );

   modport slave (
      input  cpu_addr, cpu_din, cpu_wr_n, code_cs_n, attr_cs_n,
      input  rom_data, rom_valid,
      output code_dout, attr_dout, cpu_wait_n, rom_req, rom_addr
   );

endinterface

// File: rtl/tile_layer_gen_shifter.sv
// tile_shifter: BPP 8-bit plane shifters with parallel load.
// Shift direction follows screen flip (LSB first when flipped).
module tile_shifter #(
   parameter int BPP = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ce_i,
   input  logic             load_i,
   input  logic             lsb_first_i,
   input  logic [BPP*8-1:0] din_i,
   output logic [BPP-1:0]   bits_o
);

   logic [BPP-1:0][7:0] sh_q, sh_d;

   always_comb begin
      sh_d = sh_q;
      if (load_i) begin
         sh_d = din_i;
      end else if (ce_i) begin
         for (int p = 0; p < BPP; p++) begin
            sh_d[p] = lsb_first_i ? {1'b0, sh_q[p][7:1]}
                                  : {sh_q[p][6:0], 1'b0};
         end
      end
   end

   always_comb begin
      bits_o = '0;
      for (int p = 0; p < BPP; p++) begin
         bits_o[p] = lsb_first_i ? sh_q[p][0] : sh_q[p][7];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sh_q <= '0;
      else       sh_q <= sh_d;
   end

endmodule

// File: rtl/tile_layer_gen.sv
// tile_layer_gen: 8x8 tilemap layer, map RAMs, ROM fetch FSM, pixel out.
// Define TILE_LAYER_SCROLL_EN to add scroll_x to the horizontal counter.
module tile_layer_gen
   import tile_layer_pkg::*;
#(
   parameter int MAP_COLS_LOG2 = 6,
   parameter int MAP_ROWS_LOG2 = 5,
   parameter int BPP           = 2,
   parameter int CODE_HI_BITS  = 2,
   parameter int COLOR_W       = 6,
   parameter int WAIT_SLOTS    = 2
) (
   input  logic                 master_clk,
   input  logic                 reset,
   input  logic                 pix_ce,
   input  logic [8:0]           hpix,
   input  logic [7:0]           vpix,
   input  logic                 flip,
   input  logic [8:0]           scroll_x,
   tile_layer_if.slave          bus,
   output logic [COLOR_W+BPP-1:0] pixel_out,
   output logic                 underrun
);

   localparam int MC  = MAP_COLS_LOG2;
   localparam int MR  = MAP_ROWS_LOG2;
   localparam int AW  = MC + MR;
   localparam int DW  = BPP * 8;
   localparam int RAW = rom_aw(CODE_HI_BITS);
   localparam int PW  = COLOR_W + BPP;
   localparam int WCW = cnt_w(WAIT_SLOTS);

   logic [7:0] code_ram [2**AW];
   logic [7:0] attr_ram [2**AW];
   logic [7:0] code_dout_q, attr_dout_q;

   logic [8:0]    x_raw, x;
   logic [7:0]    vrow;
   logic          ts, ld_pt;
   logic [MC-1:0] tcol, col_n;

`ifdef TILE_LAYER_SCROLL_EN
   assign x_raw = hpix + scroll_x;
`else
   assign x_raw = hpix;
   logic unused_scroll;
   assign unused_scroll = ^scroll_x;
`endif

   assign x     = flip ? ~x_raw : x_raw;
   assign vrow  = flip ? ~vpix : vpix;
   assign ts    = pix_ce & (x[2:0] == 3'd0);
   assign ld_pt = pix_ce & (x[2:0] == 3'd7);
   assign tcol  = MC'(x[8:3]);
   // Prefetch the next tile on screen, which lies to the left when flipped.
   assign col_n = flip ? tcol - MC'(1) : tcol + MC'(1);

   logic [1:0]         state_q, state_d;
   logic [AW-1:0]      map_addr_q, map_addr_d;
   logic               rom_req_q, rom_req_d;
   logic [RAW-1:0]     rom_addr_q, rom_addr_d;
   logic [DW-1:0]      stage_q, stage_d;
   logic [COLOR_W-1:0] col_stage_q, col_stage_d;
   logic [COLOR_W-1:0] colour_q, colour_d;
   logic               underrun_q, underrun_d;
   logic [PW-1:0]      pix_q, pix_d;
   logic               wait_q, wait_d;
   logic [WCW-1:0]     wcnt_q, wcnt_d;
   logic               sel_q, sel;

   logic [7:0]    code_rd, attr_rd;
   logic          load_en;
   logic [DW-1:0] load_val;
   logic [BPP-1:0] sh_out;

   assign code_rd = code_ram[map_addr_q];
   assign attr_rd = attr_ram[map_addr_q];

   always_ff @(posedge master_clk) begin
      if (!bus.code_cs_n && !bus.cpu_wr_n) code_ram[bus.cpu_addr] <= bus.cpu_din;
      if (!bus.attr_cs_n && !bus.cpu_wr_n) attr_ram[bus.cpu_addr] <= bus.cpu_din;
      code_dout_q <= code_ram[bus.cpu_addr];
      attr_dout_q <= attr_ram[bus.cpu_addr];
   end

   always_comb begin
      state_d     = state_q;
      map_addr_d  = map_addr_q;
      rom_req_d   = rom_req_q;
      rom_addr_d  = rom_addr_q;
      stage_d     = stage_q;
      col_stage_d = col_stage_q;
      colour_d    = colour_q;
      underrun_d  = underrun_q;
      load_en     = 1'b0;
      load_val    = stage_q;
      unique case (state_q)
         ST_IDLE: begin
            if (ts) begin
               map_addr_d = {MR'(vrow[7:3]), col_n};
               state_d    = ST_MAP;
            end
         end
         ST_MAP, ST_REQ: begin
            if (ld_pt) begin
               load_en    = 1'b1;
               load_val   = {DW{TRANSPARENT}};
               colour_d   = '0;
               underrun_d = 1'b1;
               rom_req_d  = 1'b0;
               state_d    = ST_IDLE;
            end else if (state_q == ST_MAP) begin
               rom_addr_d  = {attr_rd[CODE_HI_BITS-1:0], code_rd, vrow[2:0]};
               col_stage_d = attr_rd[7 -: COLOR_W];
               rom_req_d   = 1'b1;
               state_d     = ST_REQ;
            end else if (bus.rom_valid) begin
               stage_d   = bus.rom_data;
               rom_req_d = 1'b0;
               state_d   = ST_READY;
            end
         end
         ST_READY: begin
            if (ld_pt) begin
               load_en  = 1'b1;
               colour_d = col_stage_q;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign pix_d = pix_ce ? {colour_q, sh_out} : pix_q;

   // Wait counts tile strobes from the last select edge; a new edge restarts it.
   assign sel = bus.code_cs_n & bus.attr_cs_n;

   always_comb begin
      wait_d = wait_q;
      wcnt_d = wcnt_q;
      if (sel_q && !sel) begin
         wait_d = (WAIT_SLOTS != 0);
         wcnt_d = '0;
      end else if (wait_q && ts) begin
         if (wcnt_q == WCW'(WAIT_SLOTS - 1)) wait_d = 1'b0;
         wcnt_d = wcnt_q + WCW'(1);
      end
   end

   always_ff @(posedge master_clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         map_addr_q  <= '0;
         rom_req_q   <= 1'b0;
         rom_addr_q  <= '0;
         stage_q     <= '0;
         col_stage_q <= '0;
         colour_q    <= '0;
         underrun_q  <= 1'b0;
         pix_q       <= '0;
         wait_q      <= 1'b0;
         wcnt_q      <= '0;
         sel_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         map_addr_q  <= map_addr_d;
         rom_req_q   <= rom_req_d;
         rom_addr_q  <= rom_addr_d;
         stage_q     <= stage_d;
         col_stage_q <= col_stage_d;
         colour_q    <= colour_d;
         underrun_q  <= underrun_d;
         pix_q       <= pix_d;
         wait_q      <= wait_d;
         wcnt_q      <= wcnt_d;
         sel_q       <= sel;
      end
   end

   tile_shifter #(.BPP(BPP)) u_shifter (
      .clk_i       (master_clk),
      .rst_i       (reset),
      .ce_i        (pix_ce),
      .load_i      (load_en),
      .lsb_first_i (flip),
      .din_i       (load_val),
      .bits_o      (sh_out)
   );

   assign bus.code_dout  = code_dout_q;
   assign bus.attr_dout  = attr_dout_q;
   assign bus.cpu_wait_n = ~wait_q;
   assign bus.rom_req    = rom_req_q;
   assign bus.rom_addr   = rom_addr_q;
   assign pixel_out      = pix_q;
   assign underrun       = underrun_q;

endmodule

// File: tb/tb_tile_layer_gen.sv
// tb_tile_layer_gen: directed checks of fetch, flip, underrun, scroll,
// CPU wait and reset for tile_layer_gen.
module tb_tile_layer_gen;

   logic       master_clk = 1'b0;
   logic       reset = 1'b0;
   logic       pix_ce = 1'b0;
   logic [8:0] hpix = '0;
   logic [7:0] vpix = '0;
   logic       flip = 1'b0;
   logic [8:0] scroll_x = '0;
   logic [7:0] pixel_out, pixel_out0;
   logic       underrun, underrun0;

   int checks = 0;
   int passes = 0;

   logic [7:0]  cap_px [32];
   logic [12:0] cap_ra [32];
   logic        cap_rq [32];
   logic        cap_ur [32];

   tile_layer_if bus ();
   tile_layer_if bus0 ();

   assign bus0.cpu_addr  = bus.cpu_addr;
   assign bus0.cpu_din   = bus.cpu_din;
   assign bus0.cpu_wr_n  = bus.cpu_wr_n;
   assign bus0.code_cs_n = bus.code_cs_n;
   assign bus0.attr_cs_n = bus.attr_cs_n;
   assign bus0.rom_data  = bus.rom_data;
   assign bus0.rom_valid = bus.rom_valid;

   tile_layer_gen dut (
      .master_clk (master_clk),
      .reset      (reset),
      .pix_ce     (pix_ce),
      .hpix       (hpix),
      .vpix       (vpix),
      .flip       (flip),
      .scroll_x   (scroll_x),
      .bus        (bus.slave),
      .pixel_out  (pixel_out),
      .underrun   (underrun)
   );

   tile_layer_gen #(.WAIT_SLOTS(0)) dut_nw (
      .master_clk (master_clk),
      .reset      (reset),
      .pix_ce     (pix_ce),
      .hpix       (hpix),
      .vpix       (vpix),
      .flip       (flip),
      .scroll_x   (scroll_x),
      .bus        (bus0.slave),
      .pixel_out  (pixel_out0),
      .underrun   (underrun0)
   );

   always #5 master_clk = ~master_clk;

   task automatic do_reset();
      @(negedge master_clk) reset = 1'b1;
      @(negedge master_clk) reset = 1'b0;
   endtask

   task automatic step_px(input logic [8:0] h);
      @(negedge master_clk);
      hpix   = h;
      pix_ce = 1'b1;
      @(negedge master_clk);
      pix_ce = 1'b0;
      repeat (2) @(negedge master_clk);
   endtask

   task automatic run_seq(input logic [8:0] h0, input int n);
      for (int i = 0; i < n; i++) begin
         step_px(h0 + 9'(i));
         cap_px[i] = pixel_out;
         cap_ra[i] = bus.rom_addr;
         cap_rq[i] = bus.rom_req;
         cap_ur[i] = underrun;
      end
   endtask

   task automatic wr(input bit is_attr, input logic [10:0] a,
                     input logic [7:0] d);
      @(negedge master_clk);
      bus.cpu_addr = a;
      bus.cpu_din  = d;
      bus.cpu_wr_n = 1'b0;
      if (is_attr) bus.attr_cs_n = 1'b0;
      else         bus.code_cs_n = 1'b0;
      @(negedge master_clk);
      bus.cpu_wr_n  = 1'b1;
      bus.code_cs_n = 1'b1;
      bus.attr_cs_n = 1'b1;
   endtask

   task automatic pulse_cs();
      @(negedge master_clk) bus.code_cs_n = 1'b0;
      @(negedge master_clk) bus.code_cs_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (pixel_out !== 8'h00) $display("FAIL rst_pix got %h exp 00", pixel_out);
      else passes++;
      checks++;
      if (bus.rom_req !== 1'b0) $display("FAIL rst_req got %b exp 0", bus.rom_req);
      else passes++;
      checks++;
      if (bus.cpu_wait_n !== 1'b1) $display("FAIL rst_wait got %b exp 1", bus.cpu_wait_n);
      else passes++;
      checks++;
      if (underrun !== 1'b0) $display("FAIL rst_underrun got %b exp 0", underrun);
      else passes++;
   endtask

   task automatic test_cpu_port();
      wr(1'b0, 11'h015, 8'hA5);
      wr(1'b1, 11'h015, 8'h5A);
      wr(1'b0, 11'h016, 8'h3C);
      @(negedge master_clk) bus.cpu_addr = 11'h015;
      repeat (2) @(negedge master_clk);
      checks++;
      if (bus.code_dout !== 8'hA5) $display("FAIL code_rd got %h exp a5", bus.code_dout);
      else passes++;
      checks++;
      if (bus.attr_dout !== 8'h5A) $display("FAIL attr_rd got %h exp 5a", bus.attr_dout);
      else passes++;
      @(negedge master_clk) bus.cpu_addr = 11'h016;
      repeat (2) @(negedge master_clk);
      checks++;
      if (bus.code_dout !== 8'h3C) $display("FAIL code_rd2 got %h exp 3c", bus.code_dout);
      else passes++;
   endtask

   task automatic test_basic();
      do_reset();
      flip = 1'b0;
      vpix = 8'd9;
      bus.rom_valid = 1'b1;
      bus.rom_data  = 16'h0FF0;
      wr(1'b0, 11'h041, 8'h12);
      wr(1'b1, 11'h041, 8'h44);
      run_seq(9'd0, 16);
      checks++;
      if (cap_ra[0] !== 13'h091) $display("FAIL basic_rom_addr got %h exp 091", cap_ra[0]);
      else passes++;
      for (int i = 8; i < 16; i++) begin
         logic [7:0] e;
         e = (i < 12) ? 8'h45 : 8'h46;
         checks++;
         if (cap_px[i] !== e) $display("FAIL basic_px[%0d] got %h exp %h", i, cap_px[i], e);
         else passes++;
      end
   endtask

   task automatic test_flip();
      do_reset();
      flip = 1'b1;
      vpix = 8'hF6;
      run_seq(9'h1EF, 10);
      checks++;
      if (cap_ra[0] !== 13'h091) $display("FAIL flip_rom_addr got %h exp 091", cap_ra[0]);
      else passes++;
      for (int i = 2; i < 10; i++) begin
         logic [7:0] e;
         e = (i < 6) ? 8'h46 : 8'h45;
         checks++;
         if (cap_px[i] !== e) $display("FAIL flip_px[%0d] got %h exp %h", i, cap_px[i], e);
         else passes++;
      end
      flip = 1'b0;
   endtask

   task automatic test_underrun();
      do_reset();
      vpix = 8'd9;
      wr(1'b0, 11'h042, 8'h34);
      wr(1'b1, 11'h042, 8'h88);
      bus.rom_valid = 1'b0;
      run_seq(9'd0, 8);
      checks++;
      if (cap_rq[0] !== 1'b1) $display("FAIL ur_req_held got %b exp 1", cap_rq[0]);
      else passes++;
      checks++;
      if (cap_rq[7] !== 1'b0) $display("FAIL ur_req_drop got %b exp 0", cap_rq[7]);
      else passes++;
      checks++;
      if (cap_ur[7] !== 1'b1) $display("FAIL ur_flag got %b exp 1", cap_ur[7]);
      else passes++;
      bus.rom_valid = 1'b1;
      run_seq(9'd8, 16);
      checks++;
      if (cap_ra[0] !== 13'h1A1) $display("FAIL ur_next_addr got %h exp 1a1", cap_ra[0]);
      else passes++;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] e;
         e = (i < 8) ? 8'h00 : ((i < 12) ? 8'h89 : 8'h8A);
         checks++;
         if (cap_px[i] !== e) $display("FAIL ur_px[%0d] got %h exp %h", i, cap_px[i], e);
         else passes++;
      end
      checks++;
      if (cap_ur[15] !== 1'b1) $display("FAIL ur_sticky got %b exp 1", cap_ur[15]);
      else passes++;
   endtask

   task automatic test_scroll();
      do_reset();
      vpix = 8'd9;
      bus.rom_valid = 1'b1;
      scroll_x = 9'd3;
`ifdef TILE_LAYER_SCROLL_EN
      run_seq(9'h1FD, 16);
      checks++;
      if (cap_ra[0] !== 13'h091) $display("FAIL scr_rom_addr got %h exp 091", cap_ra[0]);
      else passes++;
      for (int i = 8; i < 16; i++) begin
         logic [7:0] e;
         e = (i < 12) ? 8'h45 : 8'h46;
         checks++;
         if (cap_px[i] !== e) $display("FAIL scr_px[%0d] got %h exp %h", i, cap_px[i], e);
         else passes++;
      end
      do_reset();
      scroll_x = 9'h1FF;
      wr(1'b0, 11'h07F, 8'h3F);
      wr(1'b1, 11'h07F, 8'h00);
      wr(1'b0, 11'h040, 8'h40);
      wr(1'b1, 11'h040, 8'h00);
      run_seq(9'h1F1, 9);
      checks++;
      if (cap_ra[0] !== 13'h1F9) $display("FAIL scr_col63 got %h exp 1f9", cap_ra[0]);
      else passes++;
      checks++;
      if (cap_ra[8] !== 13'h201) $display("FAIL scr_col0 got %h exp 201", cap_ra[8]);
      else passes++;
`else
      run_seq(9'd0, 16);
      checks++;
      if (cap_ra[0] !== 13'h091) $display("FAIL noscr_rom_addr got %h exp 091", cap_ra[0]);
      else passes++;
      for (int i = 8; i < 16; i++) begin
         logic [7:0] e;
         e = (i < 12) ? 8'h45 : 8'h46;
         checks++;
         if (cap_px[i] !== e) $display("FAIL noscr_px[%0d] got %h exp %h", i, cap_px[i], e);
         else passes++;
      end
`endif
      scroll_x = 9'd0;
   endtask

   task automatic test_wait();
      logic [4:0] seq_h [5];
      logic       seq_e [5];
      seq_h = '{5'd1, 5'd0, 5'd3, 5'd8, 5'd16};
      seq_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      pulse_cs();
      checks++;
      if (bus.cpu_wait_n !== 1'b0) $display("FAIL wait_assert got %b exp 0", bus.cpu_wait_n);
      else passes++;
      checks++;
      if (bus0.cpu_wait_n !== 1'b1) $display("FAIL wait0_none got %b exp 1", bus0.cpu_wait_n);
      else passes++;
      for (int i = 0; i < 5; i++) begin
         step_px(9'(seq_h[i]));
         checks++;
         if (bus.cpu_wait_n !== seq_e[i])
            $display("FAIL wait_seq[%0d] got %b exp %b", i, bus.cpu_wait_n, seq_e[i]);
         else passes++;
      end
      pulse_cs();
      step_px(9'd0);
      pulse_cs();
      step_px(9'd8);
      checks++;
      if (bus.cpu_wait_n !== 1'b0) $display("FAIL wait_restart got %b exp 0", bus.cpu_wait_n);
      else passes++;
      step_px(9'd16);
      checks++;
      if (bus.cpu_wait_n !== 1'b1) $display("FAIL wait_restart_rel got %b exp 1", bus.cpu_wait_n);
      else passes++;
      checks++;
      if (bus0.cpu_wait_n !== 1'b1) $display("FAIL wait0_stay got %b exp 1", bus0.cpu_wait_n);
      else passes++;
   endtask

   task automatic test_reset_midreq();
      do_reset();
      vpix = 8'd9;
      wr(1'b0, 11'h044, 8'h56);
      wr(1'b1, 11'h044, 8'h00);
      bus.rom_valid = 1'b0;
      run_seq(9'd0, 8);
      bus.rom_valid = 1'b1;
      run_seq(9'd8, 8);
      bus.rom_valid = 1'b0;
      run_seq(9'd16, 1);
      checks++;
      if (pixel_out !== 8'h89 || bus.rom_req !== 1'b1 || underrun !== 1'b1)
         $display("FAIL mid_pre got px=%h req=%b ur=%b exp 89/1/1",
                  pixel_out, bus.rom_req, underrun);
      else passes++;
      pulse_cs();
      reset = 1'b1;
      #1;
      checks++;
      if (pixel_out !== 8'h00) $display("FAIL mid_pix got %h exp 00", pixel_out);
      else passes++;
      checks++;
      if (bus.rom_req !== 1'b0) $display("FAIL mid_req got %b exp 0", bus.rom_req);
      else passes++;
      checks++;
      if (bus.cpu_wait_n !== 1'b1) $display("FAIL mid_wait got %b exp 1", bus.cpu_wait_n);
      else passes++;
      checks++;
      if (underrun !== 1'b0) $display("FAIL mid_underrun got %b exp 0", underrun);
      else passes++;
      @(negedge master_clk) reset = 1'b0;
      run_seq(9'd24, 1);
      checks++;
      if (cap_rq[0] !== 1'b1) $display("FAIL mid_refetch_req got %b exp 1", cap_rq[0]);
      else passes++;
      checks++;
      if (cap_ra[0] !== 13'h2B1) $display("FAIL mid_refetch_addr got %h exp 2b1", cap_ra[0]);
      else passes++;
      checks++;
      if (cap_px[0] !== 8'h00) $display("FAIL mid_refetch_px got %h exp 00", cap_px[0]);
      else passes++;
   endtask

   initial begin
      bus.cpu_addr  = '0;
      bus.cpu_din   = '0;
      bus.cpu_wr_n  = 1'b1;
      bus.code_cs_n = 1'b1;
      bus.attr_cs_n = 1'b1;
      bus.rom_data  = '0;
      bus.rom_valid = 1'b0;
      test_reset();
      test_cpu_port();
      test_basic();
      test_flip();
      test_underrun();
      test_scroll();
      test_wait();
      test_reset_midreq();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
